// File: rtl/menu_pkg.sv
// Shared types for the battle-menu selector: FSM states, action codes, menu size.
package menu_pkg;

  localparam int NUM_ITEMS = 4;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    BROWSE       = 2'd1,
    CONFIRM      = 2'd2,
    WAIT_RELEASE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    ACT_FIGHT  = 2'd0,
    ACT_ACTION = 2'd1,
    ACT_ITEM   = 2'd2,
    ACT_MERCY  = 2'd3
  } action_e;

endpackage

// File: rtl/btn_debounce.sv
// Raw button -> 2-flop sync -> debounced level plus a one-cycle press pulse on its rise.
// Level follows the synchronized input after DEBOUNCE_CYCLES stable samples; no backpressure.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_level,
  output logic o_press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    sync_q;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The count tracks consecutive samples disagreeing with the accepted level;
  // it parks at DEBOUNCE_CYCLES on the flip and clears once the level agrees.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    if (sync_q[1] == level_q) begin
      cnt_d = '0;
    end else if (cnt_q >= CW'(DEBOUNCE_CYCLES - 1)) begin
      level_d = sync_q[1];
      cnt_d   = CW'(DEBOUNCE_CYCLES);
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
    press_d = level_d & ~level_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q  <= {sync_q[0], i_btn};
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_level = level_q;
  assign o_press = press_q;

endmodule

// File: rtl/menu_select.sv
// Battle-menu cursor FSM: debounced left/right move the cursor, confirm latches a selection
// held until acknowledged; position moves the cycle after a press pulse, no backpressure.
module menu_select #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int NUM_ITEMS       = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_enable,
  input  logic       i_btn_left,
  input  logic       i_btn_right,
  input  logic       i_btn_confirm,
  input  logic       i_select_ack,
  output logic [1:0] o_cursor_position,
  output logic       o_select_valid,
  output logic [1:0] o_select_action
);

  import menu_pkg::*;

  localparam logic [1:0] LAST_POS = 2'(NUM_ITEMS - 1);

  logic [2:0] btn_raw;
  logic [2:0] btn_level;
  logic [2:0] btn_press;
  logic       unused_levels;

  assign btn_raw = {i_btn_confirm, i_btn_right, i_btn_left};

  for (genvar g = 0; g < 3; g++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_btn  (btn_raw[g]),
      .o_level(btn_level[g]),
      .o_press(btn_press[g])
    );
  end

  assign unused_levels = ^btn_level[1:0];

  state_e     state_q, state_d;
  logic [1:0] pos_q, pos_d;
  action_e    act_q, act_d;

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    act_d   = act_q;
    if (!i_enable) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: state_d = BROWSE;
        BROWSE: begin
          // Confirm takes the pre-move position and swallows any simultaneous move.
          if (btn_press[2]) begin
            act_d   = action_e'(pos_q);
            state_d = CONFIRM;
          end else if (btn_press[0] && !btn_press[1]) begin
            pos_d = (pos_q == 2'd0) ? LAST_POS : pos_q - 2'd1;
          end else if (btn_press[1] && !btn_press[0]) begin
            pos_d = (pos_q == LAST_POS) ? 2'd0 : pos_q + 2'd1;
          end
        end
        CONFIRM: begin
          if (i_select_ack) state_d = WAIT_RELEASE;
        end
        WAIT_RELEASE: begin
          if (!btn_level[2]) state_d = BROWSE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      pos_q   <= 2'd0;
      act_q   <= ACT_FIGHT;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      act_q   <= act_d;
    end
  end

  assign o_cursor_position = pos_q;
  assign o_select_valid    = (state_q == CONFIRM);
  assign o_select_action   = act_q;

endmodule

// File: tb/tb_menu_select.sv
// Randomized + directed bench: a menu-level model predicts each visible output change,
// a monitor pops and compares whenever the DUT outputs change.
module tb_menu_select;

  localparam int DC   = 4;
  localparam int GAP  = 10;

  logic       i_clk = 1'b0;
  logic       i_rst, i_enable, i_btn_left, i_btn_right, i_btn_confirm, i_select_ack;
  logic [1:0] o_cursor_position, o_select_action;
  logic       o_select_valid;

  menu_select #(.DEBOUNCE_CYCLES(DC), .NUM_ITEMS(4)) dut (
    .i_clk            (i_clk),
    .i_rst            (i_rst),
    .i_enable         (i_enable),
    .i_btn_left       (i_btn_left),
    .i_btn_right      (i_btn_right),
    .i_btn_confirm    (i_btn_confirm),
    .i_select_ack     (i_select_ack),
    .o_cursor_position(o_cursor_position),
    .o_select_valid   (o_select_valid),
    .o_select_action  (o_select_action)
  );

  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: 0 idle, 1 browsing, 2 selection pending, 3 waiting for confirm release
  int         m_mode, m_pos, m_act;
  bit         m_valid, m_chold;
  logic [4:0] m_last;
  logic [4:0] exp_q[$];
  bit         mon_on = 1'b0;
  logic [4:0] mon_last;

  function automatic logic [4:0] pack(input logic [1:0] pos, input logic valid, input logic [1:0] act);
    return {pos, valid, valid ? act : 2'b00};
  endfunction

  task automatic m_emit();
    logic [4:0] t;
    t = pack(m_pos[1:0], m_valid, m_act[1:0]);
    if (t !== m_last) begin
      exp_q.push_back(t);
      m_last = t;
    end
  endtask

  task automatic m_press(input int mask);
    if (m_mode != 1) return;
    if (mask[2]) begin
      m_act   = m_pos;
      m_mode  = 2;
      m_valid = 1'b1;
    end else if (mask[0] && !mask[1]) begin
      m_pos = (m_pos + 3) % 4;
    end else if (mask[1] && !mask[0]) begin
      m_pos = (m_pos + 1) % 4;
    end
    m_emit();
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic press(input int mask, input int hold);
    if (hold >= DC) m_press(mask);
    i_btn_left    = mask[0];
    i_btn_right   = mask[1];
    i_btn_confirm = mask[2];
    wait_cyc(hold);
    i_btn_left    = 1'b0;
    i_btn_right   = 1'b0;
    i_btn_confirm = 1'b0;
    wait_cyc(GAP);
  endtask

  task automatic ack_pulse();
    if (m_mode == 2) begin
      m_mode  = m_chold ? 3 : 1;
      m_valid = 1'b0;
      m_emit();
    end
    i_select_ack = 1'b1;
    wait_cyc(1);
    i_select_ack = 1'b0;
    wait_cyc(3);
  endtask

  task automatic set_enable(input bit en);
    if (!en) begin
      m_mode  = 0;
      m_valid = 1'b0;
      m_emit();
    end else begin
      m_mode = 1;
    end
    i_enable = en;
    wait_cyc(3);
  endtask

  task automatic do_reset();
    m_pos   = 0;
    m_act   = 0;
    m_valid = 1'b0;
    m_chold = 1'b0;
    m_mode  = i_enable ? 1 : 0;
    m_emit();
    i_rst = 1'b1;
    wait_cyc(1);
    i_rst = 1'b0;
    wait_cyc(3);
  endtask

  always @(negedge i_clk) begin
    logic [4:0] cur;
    if (mon_on) begin
      cur = pack(o_cursor_position, o_select_valid, o_select_action);
      if (cur !== mon_last) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_change at %0t: got {pos,valid,act}=%b, required no change", $time, cur);
        end else begin
          logic [4:0] e;
          e = exp_q.pop_front();
          if (cur !== e) begin
            n_bad++;
            $display("FAIL output_change at %0t: got {pos,valid,act}=%b, required %b", $time, cur, e);
          end
        end
        mon_last = cur;
      end
    end
  end

  initial begin
    int lat;
    int masks[6] = '{1, 2, 4, 3, 6, 5};
    i_rst = 1'b1; i_enable = 1'b0; i_select_ack = 1'b0;
    i_btn_left = 1'b0; i_btn_right = 1'b0; i_btn_confirm = 1'b0;
    wait_cyc(3);
    i_rst = 1'b0;
    wait_cyc(1);
    n_cmp++;
    if ({o_cursor_position, o_select_valid, o_select_action} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_state: got %b, required 00000",
               {o_cursor_position, o_select_valid, o_select_action});
    end
    m_pos = 0; m_act = 0; m_valid = 1'b0; m_mode = 0; m_chold = 1'b0;
    m_last   = 5'b0;
    mon_last = 5'b0;
    mon_on   = 1'b1;
    set_enable(1'b1);

    // First move: measure press-to-cursor latency while right is held 8 cycles
    m_press(2);
    i_btn_right = 1'b1;
    lat = -1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge i_clk);
      if (lat < 0 && o_cursor_position == 2'd1) lat = k;
    end
    i_btn_right = 1'b0;
    n_cmp++;
    if (lat < DC + 2 || lat > DC + 4) begin
      n_bad++;
      $display("FAIL first_move_latency: got %0d cycles, required %0d..%0d", lat, DC + 2, DC + 4);
    end
    wait_cyc(GAP);

    press(1, 6);                        // 1 -> 0
    press(1, 6);                        // 0 -> 3 wrap
    for (int i = 0; i < 3; i++) press(2, 6);  // 3 -> 0 -> 1 -> 2
    press(2, 3);                        // glitch rejected
    press(3, 6);                        // left+right cancel
    press(5, DC);                       // confirm at 2, move discarded
    press(1, 6);
    press(2, 6);
    press(4, 6);
    ack_pulse();

    // Confirm held through the ack must not re-confirm until released
    m_press(4);
    m_chold = 1'b1;
    i_btn_confirm = 1'b1;
    wait_cyc(GAP);
    ack_pulse();
    wait_cyc(20);
    i_btn_confirm = 1'b0;
    m_chold = 1'b0;
    if (m_mode == 3) m_mode = 1;
    wait_cyc(GAP);
    press(4, 6);
    ack_pulse();

    press(4, 6);
    set_enable(1'b0);                   // abandon pending selection
    set_enable(1'b1);
    press(2, 6);                        // 2 -> 3
    press(4, 6);
    do_reset();                         // reset mid-confirm

    for (int it = 0; it < 80; it++) begin
      int r;
      r = int'($urandom_range(0, 11));
      if (r <= 7)       press(masks[$urandom_range(0, 5)], int'($urandom_range(1, 8)));
      else if (r <= 9)  ack_pulse();
      else if (r == 10) begin set_enable(1'b0); set_enable(1'b1); end
      else if ($urandom_range(0, 2) == 0) do_reset();
      else press(2, 6);
    end

    wait_cyc(20);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL missing_changes: got %0d expected changes never seen, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
